arbitro_memoria: RTL and testbench

//   Shares one single-port unified RAM between instruction fetch (IF stage) and

---
 rtl/arbitro_memoria.sv | 129 ++++++++++++
 tb/tb_arbitro_memoria.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_memoria.sv
// Shares one single-port RAM between IF fetch and MEM data access; ARB_ROUND_ROBIN_EN enables round-robin arbitration on conflicts, otherwise MEM has fixed priority.
// Latency: ready pulses LAT+1 cycles after the request is sampled in IDLE; ram_en pulses are at least LAT+2 cycles apart.
// Backpressure: requesters hold req until their ready pulse; stall freezes the pipeline while either request is still pending.
module arbitro_memoria #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              stall,
    output logic              busy
);

    localparam int               CNT_W    = $clog2(LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state;
    logic             grant_mem;
    logic [CNT_W-1:0] cnt;
    logic             pick_mem;
    logic             any_req;

    assign any_req = if_req | mem_req;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = MEM was served last; on contention the other port wins
    logic last_grant;

    always_comb begin
        pick_mem = mem_req;
        if (if_req && mem_req) begin
            pick_mem = ~last_grant;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b0;
        end else if (state == IDLE && any_req) begin
            last_grant <= pick_mem;
        end
    end
`else
    assign pick_mem = mem_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_mem <= 1'b0;
            cnt       <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
        end else begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_mem <= pick_mem;
                        ram_en    <= 1'b1;
                        ram_we    <= pick_mem & mem_we;
                        ram_addr  <= pick_mem ? mem_addr : if_addr;
                        ram_wdata <= mem_wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= CNT_LOAD;
                    state <= WAIT;
                    // With LAT=1 the single WAIT cycle is already the ready cycle
                    if (LAT == 1) begin
                        if_ready  <= ~grant_mem;
                        mem_ready <= grant_mem;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            if_ready  <= ~grant_mem;
                            mem_ready <= grant_mem;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata  = ram_rdata;
    assign mem_rdata = ram_rdata;
    assign stall     = (if_req & ~if_ready) | (mem_req & ~mem_ready);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_arbitro_memoria.sv
// Bench for arbitro_memoria: instance 0 runs LAT=1, instance 1 runs LAT=3, each with a latency-accurate RAM model.
module tb_arbitro_memoria;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic [31:0] if_rdata  [2];
    logic        if_ready  [2];
    logic        mem_req   [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        mem_ready [2];
    logic        ram_en    [2];
    logic        ram_we    [2];
    logic [31:0] ram_addr  [2];
    logic [31:0] ram_wdata [2];
    logic [31:0] ram_rdata [2];
    logic        stall     [2];
    logic        busy      [2];
    logic        pre_we    [2];
    logic [31:0] pre_addr;
    logic [31:0] pre_dat;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        logic [31:0] ram_arr [256];
        logic [31:0] pipe [L];

        arbitro_memoria #(.ADDR_W(32), .DATA_W(32), .LAT(L)) u_dut (
            .clk       (clk),
            .reset     (rst[g]),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_rdata  (if_rdata[g]),
            .if_ready  (if_ready[g]),
            .mem_req   (mem_req[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .mem_ready (mem_ready[g]),
            .ram_en    (ram_en[g]),
            .ram_we    (ram_we[g]),
            .ram_addr  (ram_addr[g]),
            .ram_wdata (ram_wdata[g]),
            .ram_rdata (ram_rdata[g]),
            .stall     (stall[g]),
            .busy      (busy[g])
        );

        // Read data is only meaningful exactly L cycles after a read strobe
        always @(posedge clk) begin
            if (pre_we[g]) ram_arr[pre_addr[9:2]] <= pre_dat;
            else if (ram_en[g] && ram_we[g]) ram_arr[ram_addr[g][9:2]] <= ram_wdata[g];
            pipe[0] <= (ram_en[g] && !ram_we[g]) ? ram_arr[ram_addr[g][9:2]] : 32'hBADB_AD00;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign ram_rdata[g] = pipe[L-1];
    end

    typedef struct packed {
        logic        mem;
        logic [7:0]  cyc;
        logic [31:0] dat;
    } rsp_t;

    typedef struct {
        logic        en, we, ir, mr, st, bz;
        logic [31:0] ra, wd;
    } obs_t;

    rsp_t exp_q[$];
    rsp_t got_q[$];
    obs_t tr [16];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic rsp_t rsp(input logic m, input int c, input logic [31:0] v);
        rsp_t r;
        r.mem = m;
        r.cyc = 8'(c);
        r.dat = v;
        return r;
    endfunction

    // mode 0: drop a req on its ready; 1: hold reqs; 2: at cycle 1 drop reqs and scramble addr/wdata
    task automatic run(input int d, input int n, input int mode);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            tr[c].en = ram_en[d];   tr[c].we = ram_we[d];
            tr[c].ir = if_ready[d]; tr[c].mr = mem_ready[d];
            tr[c].st = stall[d];    tr[c].bz = busy[d];
            tr[c].ra = ram_addr[d]; tr[c].wd = ram_wdata[d];
            if (if_ready[d]) got_q.push_back(rsp(1'b0, c, if_rdata[d]));
            if (mem_ready[d]) got_q.push_back(rsp(1'b1, c, mem_we[d] ? 32'h0 : mem_rdata[d]));
            if (mode == 0) begin
                if (if_ready[d]) if_req[d] = 1'b0;
                if (mem_ready[d]) mem_req[d] = 1'b0;
            end
            if (mode == 2 && c == 1) begin
                if_req[d] = 1'b0;        mem_req[d] = 1'b0;
                if_addr[d] = 32'h80;     mem_addr[d] = 32'h80;
                mem_wdata[d] = 32'hFFFF_FFFF;
            end
        end
    endtask

    task automatic preload(input int d, input logic [31:0] a, input logic [31:0] v);
        @(posedge clk); #1;
        pre_we[d] = 1'b1; pre_addr = a; pre_dat = v;
        @(posedge clk); #1;
        pre_we[d] = 1'b0;
    endtask

    task automatic pulse_reset(input int d);
        @(posedge clk); #1; rst[d] = 1'b1;
        @(posedge clk); #1; rst[d] = 1'b0;
    endtask

    task automatic test_reset;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; pre_we[d] = 1'b0;
            if_req[d] = 1'b0; if_addr[d] = '0;
            mem_req[d] = 1'b0; mem_we[d] = 1'b0; mem_addr[d] = '0; mem_wdata[d] = '0;
        end
        pre_addr = '0; pre_dat = '0;
        if_req[0] = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({ram_en[d], ram_we[d], if_ready[d], mem_ready[d], busy[d]} !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_ctrl[%0d]: en,we,if_rdy,mem_rdy,busy=%b expected 00000", d,
                         {ram_en[d], ram_we[d], if_ready[d], mem_ready[d], busy[d]});
            end
            n_cmp++;
            if ({ram_addr[d], ram_wdata[d]} !== 64'h0) begin
                n_bad++;
                $display("FAIL reset_bus[%0d]: addr=%h wdata=%h expected 0", d, ram_addr[d], ram_wdata[d]);
            end
        end
        n_cmp++;
        if (stall[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_stall: got %b expected 1 with if_req held", stall[0]);
        end
        if_req[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_fetch;
        rsp_t e, g;
        preload(0, 32'h10, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        if_addr[0] = 32'h10; if_req[0] = 1'b1;
        exp_q.push_back(rsp(1'b0, 2, 32'hDEAD_BEEF));
        run(0, 5, 0);
        n_cmp++;
        if ({tr[0].en, tr[1].en, tr[2].en, tr[3].en} !== 4'b0100) begin
            n_bad++;
            $display("FAIL fetch_en: cycles0-3 ram_en=%b%b%b%b expected 0100", tr[0].en, tr[1].en, tr[2].en, tr[3].en);
        end
        n_cmp++;
        if (tr[1].we !== 1'b0 || tr[1].ra !== 32'h10) begin
            n_bad++;
            $display("FAIL fetch_addr: we=%b addr=%h expected 0/00000010", tr[1].we, tr[1].ra);
        end
        n_cmp++;
        if ({tr[1].st, tr[3].st, tr[4].st} !== 3'b100) begin
            n_bad++;
            $display("FAIL fetch_stall: cyc1,3,4=%b%b%b expected 100", tr[1].st, tr[3].st, tr[4].st);
        end
        n_cmp++;
        if ({tr[0].bz, tr[1].bz, tr[2].bz, tr[3].bz} !== 4'b0110) begin
            n_bad++;
            $display("FAIL fetch_busy: cycles0-3=%b%b%b%b expected 0110", tr[0].bz, tr[1].bz, tr[2].bz, tr[3].bz);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++; $display("FAIL fetch_sb: none, expected mem=%0d cyc=%0d dat=%h", e.mem, e.cyc, e.dat);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin n_bad++; $display("FAIL fetch_sb: got mem=%0d cyc=%0d dat=%h expected mem=%0d cyc=%0d dat=%h", g.mem, g.cyc, g.dat, e.mem, e.cyc, e.dat); end
            end
        end
        n_cmp++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL fetch_extra: %0d extra ready pulses expected 0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_store_load;
        rsp_t e, g;
        @(posedge clk); #1;
        mem_we[0] = 1'b1; mem_addr[0] = 32'h40; mem_wdata[0] = 32'h1234_5678; mem_req[0] = 1'b1;
        exp_q.push_back(rsp(1'b1, 2, 32'h0));
        run(0, 4, 0);
        n_cmp++;
        if ({tr[1].en, tr[1].we, tr[2].en, tr[2].we} !== 4'b1100) begin
            n_bad++;
            $display("FAIL store_strobe: en,we c1=%b%b c2=%b%b expected 11 00", tr[1].en, tr[1].we, tr[2].en, tr[2].we);
        end
        n_cmp++;
        if (tr[1].ra !== 32'h40 || tr[1].wd !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL store_bus: addr=%h wdata=%h expected 00000040/12345678", tr[1].ra, tr[1].wd);
        end
        @(posedge clk); #1;
        mem_we[0] = 1'b0; mem_addr[0] = 32'h40; mem_req[0] = 1'b1;
        exp_q.push_back(rsp(1'b1, 2, 32'h1234_5678));
        run(0, 4, 2);
        n_cmp++;
        if (tr[1].we !== 1'b0 || tr[2].ra !== 32'h40) begin
            n_bad++;
            $display("FAIL load_hold: we=%b addr after scramble=%h expected 0/00000040", tr[1].we, tr[2].ra);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++; $display("FAIL stld_sb: none, expected mem=%0d cyc=%0d dat=%h", e.mem, e.cyc, e.dat);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin n_bad++; $display("FAIL stld_sb: got mem=%0d cyc=%0d dat=%h expected mem=%0d cyc=%0d dat=%h", g.mem, g.cyc, g.dat, e.mem, e.cyc, e.dat); end
            end
        end
        n_cmp++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL stld_extra: %0d extra ready pulses expected 0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_conflict;
        rsp_t e, g;
        pulse_reset(0);
        @(posedge clk); #1;
        if_addr[0] = 32'h10; mem_we[0] = 1'b0; mem_addr[0] = 32'h40;
        if_req[0] = 1'b1; mem_req[0] = 1'b1;
        exp_q.push_back(rsp(1'b1, 2, 32'h1234_5678));
        exp_q.push_back(rsp(1'b0, 5, 32'hDEAD_BEEF));
        run(0, 7, 0);
        n_cmp++;
        if ({tr[1].en, tr[2].en, tr[3].en, tr[4].en, tr[5].en} !== 5'b10010) begin
            n_bad++;
            $display("FAIL conf_en: cycles1-5=%b%b%b%b%b expected 10010", tr[1].en, tr[2].en, tr[3].en, tr[4].en, tr[5].en);
        end
        n_cmp++;
        if (tr[1].ra !== 32'h40 || tr[4].ra !== 32'h10) begin
            n_bad++;
            $display("FAIL conf_addr: first=%h second=%h expected 00000040/00000010", tr[1].ra, tr[4].ra);
        end
        n_cmp++;
        if ({tr[1].st, tr[2].st, tr[3].st, tr[4].st, tr[5].st} !== 5'b11110) begin
            n_bad++;
            $display("FAIL conf_stall: cycles1-5=%b%b%b%b%b expected 11110", tr[1].st, tr[2].st, tr[3].st, tr[4].st, tr[5].st);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++; $display("FAIL conf_sb: none, expected mem=%0d cyc=%0d dat=%h", e.mem, e.cyc, e.dat);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin n_bad++; $display("FAIL conf_sb: got mem=%0d cyc=%0d dat=%h expected mem=%0d cyc=%0d dat=%h", g.mem, g.cyc, g.dat, e.mem, e.cyc, e.dat); end
            end
        end
        n_cmp++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL conf_extra: %0d extra ready pulses expected 0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_latency;
        rsp_t e, g;
        preload(1, 32'h20, 32'hA5A5_0003);
        @(posedge clk); #1;
        mem_we[1] = 1'b0; mem_addr[1] = 32'h20; mem_req[1] = 1'b1;
        exp_q.push_back(rsp(1'b1, 4, 32'hA5A5_0003));
        run(1, 7, 0);
        n_cmp++;
        if ({tr[0].en, tr[1].en, tr[2].en, tr[3].en, tr[4].en} !== 5'b01000) begin
            n_bad++;
            $display("FAIL lat_en: cycles0-4=%b%b%b%b%b expected 01000", tr[0].en, tr[1].en, tr[2].en, tr[3].en, tr[4].en);
        end
        n_cmp++;
        if ({tr[0].bz, tr[1].bz, tr[2].bz, tr[3].bz, tr[4].bz, tr[5].bz} !== 6'b011110) begin
            n_bad++;
            $display("FAIL lat_busy: cycles0-5=%b%b%b%b%b%b expected 011110", tr[0].bz, tr[1].bz, tr[2].bz, tr[3].bz, tr[4].bz, tr[5].bz);
        end
        n_cmp++;
        if ({tr[3].st, tr[4].st} !== 2'b10) begin
            n_bad++;
            $display("FAIL lat_stall: cycles3-4=%b%b expected 10", tr[3].st, tr[4].st);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++; $display("FAIL lat_sb: none, expected mem=%0d cyc=%0d dat=%h", e.mem, e.cyc, e.dat);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin n_bad++; $display("FAIL lat_sb: got mem=%0d cyc=%0d dat=%h expected mem=%0d cyc=%0d dat=%h", g.mem, g.cyc, g.dat, e.mem, e.cyc, e.dat); end
            end
        end
        n_cmp++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL lat_extra: %0d extra ready pulses expected 0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_reset_mid;
        rsp_t e, g;
        int   pulses = 0;
        @(posedge clk); #1;
        mem_we[1] = 1'b0; mem_addr[1] = 32'h20; mem_req[1] = 1'b1;
        run(1, 2, 0);
        @(posedge clk); #1;
        n_cmp++;
        if (busy[1] !== 1'b1) begin
            n_bad++; $display("FAIL rmid_pre: busy=%b expected 1 in WAIT", busy[1]);
        end
        rst[1] = 1'b1; mem_req[1] = 1'b0;
        #1;
        n_cmp++;
        if ({ram_en[1], busy[1], mem_ready[1]} !== 3'b000) begin
            n_bad++; $display("FAIL rmid_async: en,busy,ready=%b expected 000", {ram_en[1], busy[1], mem_ready[1]});
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_ready[1] || ram_en[1] || busy[1]) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++; $display("FAIL rmid_quiet: %0d active cycles during reset expected 0", pulses);
        end
        @(posedge clk); #1; rst[1] = 1'b0;
        @(posedge clk); #1;
        mem_req[1] = 1'b1;
        exp_q.push_back(rsp(1'b1, 4, 32'hA5A5_0003));
        run(1, 7, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++; $display("FAIL rmid_sb: none, expected mem=%0d cyc=%0d dat=%h", e.mem, e.cyc, e.dat);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin n_bad++; $display("FAIL rmid_sb: got mem=%0d cyc=%0d dat=%h expected mem=%0d cyc=%0d dat=%h", g.mem, g.cyc, g.dat, e.mem, e.cyc, e.dat); end
            end
        end
        n_cmp++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL rmid_extra: %0d extra ready pulses expected 0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_back_to_back;
        rsp_t       e, g;
        logic [11:0] en_got, en_exp;
        pulse_reset(0);
        @(posedge clk); #1;
        if_addr[0] = 32'h10; mem_we[0] = 1'b0; mem_addr[0] = 32'h40;
        if_req[0] = 1'b1; mem_req[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (k % 2 == 0) exp_q.push_back(rsp(1'b1, 3 * k + 2, 32'h1234_5678));
            else exp_q.push_back(rsp(1'b0, 3 * k + 2, 32'hDEAD_BEEF));
`else
            exp_q.push_back(rsp(1'b1, 3 * k + 2, 32'h1234_5678));
`endif
        end
        run(0, 12, 1);
        if_req[0] = 1'b0; mem_req[0] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            en_got[c] = tr[c].en;
            en_exp[c] = (c % 3 == 1);
        end
        n_cmp++;
        if (en_got !== en_exp) begin
            n_bad++; $display("FAIL b2b_en: ram_en pattern=%b expected %b", en_got, en_exp);
        end
        n_cmp++;
        if (tr[11].st !== 1'b1) begin
            n_bad++; $display("FAIL b2b_stall: cycle11 stall=%b expected 1", tr[11].st);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++; $display("FAIL b2b_sb: none, expected mem=%0d cyc=%0d dat=%h", e.mem, e.cyc, e.dat);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin n_bad++; $display("FAIL b2b_sb: got mem=%0d cyc=%0d dat=%h expected mem=%0d cyc=%0d dat=%h", g.mem, g.cyc, g.dat, e.mem, e.cyc, e.dat); end
            end
        end
        n_cmp++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL b2b_extra: %0d extra ready pulses expected 0", got_q.size()); got_q.delete(); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy[0] !== 1'b0 || stall[0] !== 1'b0) begin
            n_bad++; $display("FAIL b2b_idle: busy=%b stall=%b expected 0/0", busy[0], stall[0]);
        end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_store_load;
        test_conflict;
        test_latency;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
